injector: RTL and testbench

- Local-injection counterpart of the router's ejection path. Accepts flits from the local PE through a valid/ready handshake and buffers them in a small FIFO.
- Each cycle, places the head flit onto one free router channel, chosen round-robin among the free ones.
- Output is a registered flit plus a one-hot injection vector for the channel muxes after port allocation.
- Flags local starvation when the head flit waits too long for a free channel.

---
 rtl/injector_pkg.sv | 14 +
 rtl/injector_if.sv | 26 ++
 rtl/injector_rr_pick.sv | 38 +++
 rtl/injector.sv | 120 ++++++++++++
 tb/tb_injector.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/injector_pkg.sv
// Shared constants and helpers for the local injection path.
package injector_pkg;

    localparam int unsigned WIDTH_PORT       = 8;
    localparam int unsigned NUM_CHANNEL      = 5;
    localparam int unsigned DEPTH_INJ        = 4;
    localparam int unsigned STARVE_LIMIT_INJ = 15;

    // Index width that stays at least 1 bit for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/injector_if.sv
// PE-side handshake and router-side injection signals of the injector.
interface injector_if
    import injector_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_PORT,
    parameter int unsigned NUM_CH = NUM_CHANNEL
);

    logic [WIDTH-1:0]  peFlit;
    logic              peValid;
    logic              peReady;
    logic [NUM_CH-1:0] freeVector;
    logic [WIDTH-1:0]  injFlit;
    logic [NUM_CH-1:0] injVector;

    modport master (
        output peFlit, peValid, freeVector,
        input  peReady, injFlit, injVector
    );

    modport slave (
        input  peFlit, peValid, freeVector,
        output peReady, injFlit, injVector
    );

endinterface

// File: rtl/injector_rr_pick.sv
// Round-robin pick of one free channel, scanning upward from rr_ptr with wrap.
module injector_rr_pick
    import injector_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CHANNEL,
    parameter int unsigned CH_W   = idx_w(NUM_CHANNEL)
) (
    input  logic [NUM_CH-1:0] free_vec,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    int unsigned      cand;
    logic [CH_W-1:0]  cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = CH_W'(cand);
            if (!found && free_vec[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/injector.sv
// Local PE injection: small FIFO feeding one round-robin-chosen free router channel per cycle.
module injector
    import injector_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_PORT,
    parameter int unsigned NUM_CH       = NUM_CHANNEL,
    parameter int unsigned DEPTH        = DEPTH_INJ,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_INJ
) (
    input  logic                   clk,
    input  logic                   rst_n,
    injector_if.slave              bus,
    output logic                   starve,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned CH_W   = idx_w(NUM_CH);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  inj_flit_q, inj_flit_d;
    logic [NUM_CH-1:0] inj_vec_q, inj_vec_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;

    logic              pe_ready;
    logic              push;
    logic              pop;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;

    injector_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .free_vec  (bus.freeVector),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready depends on registered occupancy only; a same-cycle pop never frees a slot for a push.
    assign pe_ready = (occ_q != OCC_W'(DEPTH));
    assign push     = bus.peValid && pe_ready;
    assign pop      = (occ_q != '0) && (bus.freeVector != '0);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        rr_ptr_d   = rr_ptr_q;
        inj_flit_d = '0;
        inj_vec_d  = '0;
        wait_d     = wait_q;
        starve_d   = (wait_q == WAIT_W'(STARVE_LIMIT));

        if (push) begin
            mem_d[wr_ptr_q] = bus.peFlit;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            inj_flit_d = mem_q[rd_ptr_q];
            inj_vec_d  = grant;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rr_ptr_d   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (pop || (occ_q == '0)) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            rr_ptr_q   <= '0;
            inj_flit_q <= '0;
            inj_vec_q  <= '0;
            wait_q     <= '0;
            starve_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            rr_ptr_q   <= rr_ptr_d;
            inj_flit_q <= inj_flit_d;
            inj_vec_q  <= inj_vec_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.peReady   = pe_ready;
    assign bus.injFlit   = inj_flit_q;
    assign bus.injVector = inj_vec_q;
    assign starve        = starve_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_injector.sv
// Bench for injector: directed vector table, hand sequences and random traffic vs a queue model.
module tb_injector;

    localparam int unsigned W     = 8;
    localparam int unsigned NC    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 15;

    logic       clk;
    logic       rst_n;
    logic       starve;
    logic [2:0] occupancy;

    injector_if #(.WIDTH(W), .NUM_CH(NC)) bus ();

    injector #(
        .WIDTH        (W),
        .NUM_CH       (NC),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .starve    (starve),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue of buffered flits plus RR/starvation bookkeeping.
    logic [W-1:0]  mq[$];
    int            m_rr;
    int            m_wait;
    bit            m_starve;
    logic [W-1:0]  m_flit;
    logic [NC-1:0] m_vec;

    typedef struct {
        bit            rst;
        bit            v;
        logic [W-1:0]  f;
        logic [NC-1:0] fr;
        logic [NC-1:0] ev;
        logic [W-1:0]  ef;
        int            eo;
        bit            er;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_rr     = 0;
        m_wait   = 0;
        m_starve = 0;
        m_flit   = '0;
        m_vec    = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] f, input logic [NC-1:0] fr);
        int  occ_before = mq.size();
        bit  ready      = (occ_before != DEPTH);
        bit  do_push    = v && ready;
        bit  do_pop     = (occ_before != 0) && (fr != '0);
        int  ch         = -1;
        m_starve = (m_wait == LIMIT);
        if (do_pop) begin
            for (int k = 0; k < NC; k++) begin
                int c = (m_rr + k) % NC;
                if (ch < 0 && fr[c]) ch = c;
            end
            m_flit = mq.pop_front();
            m_vec  = NC'(1) << ch;
            m_rr   = (ch + 1) % NC;
        end else begin
            m_flit = '0;
            m_vec  = '0;
        end
        if (do_pop || occ_before == 0) m_wait = 0;
        else if (m_wait < LIMIT) m_wait = m_wait + 1;
        if (do_push) mq.push_back(f);
    endfunction

    task automatic check_model();
        chk("inj_vector", 32'(bus.injVector), 32'(m_vec));
        chk("inj_flit",   32'(bus.injFlit),   32'(m_flit));
        chk("occupancy",  32'(occupancy),     32'(mq.size()));
        chk("pe_ready",   32'(bus.peReady),   32'(mq.size() != DEPTH));
        chk("starve",     32'(starve),        32'(m_starve));
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] f, input logic [NC-1:0] fr);
        bus.peValid    = v;
        bus.peFlit     = f;
        bus.freeVector = fr;
        model_step(v, f, fr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        bus.peValid    = 1'b0;
        bus.peFlit     = '0;
        bus.freeVector = '0;
        rst_n          = 1'b0;
        model_reset();
        #1;
        chk("rst_occupancy", 32'(occupancy),     32'd0);
        chk("rst_inj_vec",   32'(bus.injVector), 32'd0);
        chk("rst_inj_flit",  32'(bus.injFlit),   32'd0);
        chk("rst_starve",    32'(starve),        32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'hA5, 5'b00100, 5'b00000, 8'h00, 1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 5'b00100, 5'b00100, 8'hA5, 0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 5'b00100, 5'b00000, 8'h00, 0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 8'h11, 5'b00000, 5'b00000, 8'h00, 1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 5'b00000, 5'b00000, 8'h00, 2, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h33, 5'b00000, 5'b00000, 8'h00, 3, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h44, 5'b00000, 5'b00000, 8'h00, 4, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h55, 5'b00000, 5'b00000, 8'h00, 4, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 5'b11111, 5'b00001, 8'h11, 3, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 5'b11111, 5'b00010, 8'h22, 2, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 5'b11111, 5'b00100, 8'h33, 1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 5'b11111, 5'b01000, 8'h44, 0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 5'b11111, 5'b00000, 8'h00, 0, 1'b1};

        do_reset();

        // Idle with every channel free.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 5'b11111);
            chk("idle_ready", 32'(bus.peReady),   32'd1);
            chk("idle_vec",   32'(bus.injVector), 32'd0);
        end

        // Single-flit latency, then fill-to-full and RR drain.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].v, tbl[i].f, tbl[i].fr);
            chk($sformatf("tbl%0d_vec", i),   32'(bus.injVector), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_flit", i),  32'(bus.injFlit),   32'(tbl[i].ef));
            chk($sformatf("tbl%0d_occ", i),   32'(occupancy),     32'(tbl[i].eo));
            chk($sformatf("tbl%0d_ready", i), 32'(bus.peReady),   32'(tbl[i].er));
        end

        // Starvation: one flit blocked, starve rises one cycle after the counter saturates.
        do_reset();
        cycle(1'b1, 8'h77, 5'b00000);
        for (int j = 1; j <= 16; j++) begin
            cycle(1'b0, 8'h00, 5'b00000);
            chk($sformatf("starve_blk%0d", j), 32'(starve), 32'(j == 16));
        end
        cycle(1'b0, 8'h00, 5'b10000);
        chk("starve_pop_vec",  32'(bus.injVector), 32'h10);
        chk("starve_pop_flit", 32'(bus.injFlit),   32'h77);
        cycle(1'b0, 8'h00, 5'b10000);
        chk("starve_clear", 32'(starve), 32'd0);

        // Streaming at one flit per cycle over two channels.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i + 1), 5'b00011);
            if (i >= 1) begin
                chk("stream_vec",  32'(bus.injVector), (i % 2 == 1) ? 32'h1 : 32'h2);
                chk("stream_flit", 32'(bus.injFlit),   32'(i));
                chk("stream_occ",  32'(occupancy),     32'd1);
            end
        end

        // Mid-operation reset flushes the buffered flits.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 5'b00000);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 5'b11111);
            chk("post_rst_vec", 32'(bus.injVector), 32'd0);
        end

        // Random traffic with periodic fully-blocked stretches.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [NC-1:0] fr;
            if ((i % 200) < 20 || $urandom_range(0, 9) < 2) fr = '0;
            else fr = NC'($urandom);
            cycle(1'($urandom_range(0, 1)), W'($urandom), fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
